map_bram_arbiter: RTL and testbench
===================================

Name: map_bram_arbiter

Overview:
- Shares the single-port 128x128x4-bit map tile RAM between three requesters: the video renderer, the ball-physics collision lookup, and the map-editor writer.
- Video has absolute priority whenever it needs a read. Collision reads and editor writes share the remaining slots round-robin.
- Read data is routed back to its requester through a 2-stage tag pipeline that matches the RAM's HIGH_PERFORMANCE read latency.
- Sits between the map sprite renderer and the map RAM instance.

Parameters:
- ADDR_W, 14: map RAM address width (WIDTH*HEIGHT = 16384).
- DATA_W, 4: tile index width.
- RD_LAT, 2: RAM read latency in cycles (address edge to valid douta).
- WR_BLANK_ONLY, 1: when 1, editor writes are granted only while vid_active_in=0.

Ports:
- pixel_clk_in, input, 1: clock.
- rst_in, input, 1: synchronous, active-low reset.
- vid_active_in, input, 1: video needs a RAM read this cycle.
- vid_addr_in, input, ADDR_W: video read address.
- vid_data_out, output, DATA_W: video read data.
- vid_valid_out, output, 1: vid_data_out valid.
- col_req_in, input, 1: collision read request.
- col_addr_in, input, ADDR_W: collision address, held stable until accepted.
- col_ready_out, output, 1: collision request accepted this cycle.
- col_data_out, output, DATA_W: collision read data.
- col_valid_out, output, 1: col_data_out valid.
- wr_req_in, input, 1: editor write request.
- wr_addr_in, input, ADDR_W: write address.
- wr_data_in, input, DATA_W: write data.
- wr_ready_out, output, 1: write accepted this cycle.
- wr_done_out, output, 1: one-cycle pulse, the cycle after the write is accepted.
- ram_addr_out, output, ADDR_W: to RAM addra.
- ram_din_out, output, DATA_W: to RAM dina.
- ram_we_out, output, 1: to RAM wea.
- ram_dout_in, input, DATA_W: from RAM douta.

Behaviour:
- Reset (rst_in=0 at an edge):
  - Tag pipeline cleared to NONE; all in-flight responses are dropped.
  - rr_last <= WR, so collision wins the first contention.
  - wr_done_out, vid_valid_out, col_valid_out = 0.
  - While rst_in=0, ready outputs and ram_we_out are forced 0.
- Arbitration, combinational each cycle:
  - vid_active_in=1: grant VID. ram_addr_out = vid_addr_in, ram_we_out = 0.
  - Otherwise candidates are col_req_in and wr_req_in. wr is eligible only if !(WR_BLANK_ONLY && vid_active_in); with video idle this always holds.
  - Both eligible: grant the one that is not rr_last.
  - Only one eligible: grant it.
  - None: grant NONE; ram_addr_out holds its last value, ram_we_out = 0.
- Grant effects:
  - COL: col_ready_out = 1, ram_addr_out = col_addr_in.
  - WR: wr_ready_out = 1, ram_we_out = 1, ram_addr_out = wr_addr_in, ram_din_out = wr_data_in.
  - rr_last updates only on a COL or WR grant.
- Tag pipeline, 2 stages, tag in {NONE, VID, COL}:
  - Stage 0 loads the tag of the granted read. A write or idle loads NONE.
  - Responses: vid_valid_out = (stage1==VID); col_valid_out = (stage1==COL). Both data outputs = ram_dout_in.
  - Latency: exactly RD_LAT=2 cycles from grant to valid. Responses return in order, fully pipelined, one per cycle.
- wr_done_out is registered: 1 in the cycle after a WR grant.
- Hazards:
  - A read of an address in the cycle after its write returns the new data.
  - A simultaneous read and write of the same address cannot occur (single grant per cycle).
- Starvation: video may starve col/wr indefinitely by design. Col and wr never starve each other: after one grant, the other wins the next contended slot.
- Requester holding rules: a requester holds req/addr/data until ready. Deasserting req before ready is legal and simply withdraws the request.

Optional Feature:
- Macro: MAP_ARB_STATS_EN.
- Defined: adds three 16-bit saturating counters, cleared on reset:
  - col_grants_out: counts COL grants.
  - wr_grants_out: counts WR grants.
  - col_stall_out: counts cycles with col_req_in=1 and col_ready_out=0.
  - Each counter holds at 16'hFFFF when saturated.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_in=0 for 3 cycles, then 1, no requests -> all valids, readies, wr_done_out and ram_we_out stay 0.
- Video stream: vid_active_in=1, vid_addr_in=0..9 on consecutive cycles, RAM preloaded data = addr[3:0] -> vid_valid_out rises 2 cycles after the first address, vid_data_out = 0..9 in order, col_ready_out=0 throughout.
- Contention: vid_active_in=0, col_req_in and wr_req_in both held for 4 cycles -> grants alternate COL, WR, COL, WR; wr_done_out pulses the cycle after each WR grant.
- Blank-only write: WR_BLANK_ONLY=1, vid_active_in=1, wr_req_in=1 for 5 cycles, then vid_active_in=0 -> wr_ready_out=0 for those 5 cycles, then 1 in the first blank cycle.
- Write-then-read: write addr 0x1234 data 0xA, then collision read of 0x1234 next cycle -> col_valid_out with col_data_out=0xA 2 cycles after the read grant.
- Reset mid-flight: collision read granted, rst_in=0 on the next edge -> col_valid_out never asserts for that read; rr_last=WR, so the next contention grants COL.

Source files
------------

// File: rtl/map_bram_arbiter.sv
// map_bram_arbiter
// Shares the single-port map tile RAM between the video renderer, the
// ball-physics collision lookup and the map-editor writer. Video always wins;
// collision reads and editor writes alternate on contended slots. Read data is
// steered back to its requester by a tag pipeline matching the RAM latency.
// Optional build macro: MAP_ARB_STATS_EN adds saturating grant/stall counters.
module map_bram_arbiter #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 4,
  parameter int RD_LAT        = 2,
  parameter int WR_BLANK_ONLY = 1
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              vid_active_in,
  input  logic [ADDR_W-1:0] vid_addr_in,
  output logic [DATA_W-1:0] vid_data_out,
  output logic              vid_valid_out,
  input  logic              col_req_in,
  input  logic [ADDR_W-1:0] col_addr_in,
  output logic              col_ready_out,
  output logic [DATA_W-1:0] col_data_out,
  output logic              col_valid_out,
  input  logic              wr_req_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ready_out,
  output logic              wr_done_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_din_out,
  output logic              ram_we_out,
  input  logic [DATA_W-1:0] ram_dout_in
`ifdef MAP_ARB_STATS_EN
  ,
  output logic [15:0]       col_grants_out,
  output logic [15:0]       wr_grants_out,
  output logic [15:0]       col_stall_out
`endif
);

  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_COL, GNT_WR} grant_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_COL} tag_t;
  typedef enum logic {RR_COL, RR_WR} rr_t;

  grant_t            grant;
  rr_t               rr_last;
  tag_t              new_tag;
  tag_t              tag_pipe [RD_LAT];
  logic [ADDR_W-1:0] addr_hold;
  logic              wr_eligible;

  // Pick the single owner of the RAM port for this cycle; nothing is granted in reset.
  always_comb begin
    grant       = GNT_NONE;
    wr_eligible = wr_req_in && !((WR_BLANK_ONLY != 0) && vid_active_in);
    if (rst_in) begin
      if (vid_active_in) begin
        grant = GNT_VID;
      end else if (col_req_in && wr_eligible) begin
        grant = (rr_last == RR_WR) ? GNT_COL : GNT_WR;
      end else if (col_req_in) begin
        grant = GNT_COL;
      end else if (wr_eligible) begin
        grant = GNT_WR;
      end
    end
  end

  // Drive the RAM port and handshakes from the grant; idle slots keep the last address.
  always_comb begin
    ram_addr_out  = addr_hold;
    ram_din_out   = wr_data_in;
    ram_we_out    = 1'b0;
    col_ready_out = 1'b0;
    wr_ready_out  = 1'b0;
    new_tag       = TAG_NONE;
    case (grant)
      GNT_VID: begin
        ram_addr_out = vid_addr_in;
        new_tag      = TAG_VID;
      end
      GNT_COL: begin
        ram_addr_out  = col_addr_in;
        col_ready_out = 1'b1;
        new_tag       = TAG_COL;
      end
      GNT_WR: begin
        ram_addr_out = wr_addr_in;
        ram_we_out   = 1'b1;
        wr_ready_out = 1'b1;
      end
      default: begin
        ram_addr_out = addr_hold;
      end
    endcase
  end

  // Round-robin memory, write-done pulse and held idle address.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      rr_last     <= RR_WR;
      wr_done_out <= 1'b0;
      addr_hold   <= '0;
    end else begin
      if (grant == GNT_COL) rr_last <= RR_COL;
      else if (grant == GNT_WR) rr_last <= RR_WR;
      wr_done_out <= (grant == GNT_WR);
      addr_hold   <= ram_addr_out;
    end
  end

  // Tag pipeline that follows each read through the RAM so data reaches the right requester.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign vid_valid_out = (tag_pipe[RD_LAT-1] == TAG_VID);
  assign col_valid_out = (tag_pipe[RD_LAT-1] == TAG_COL);
  assign vid_data_out  = ram_dout_in;
  assign col_data_out  = ram_dout_in;

`ifdef MAP_ARB_STATS_EN
  // Saturating counters for collision/write grants and collision stall cycles.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      col_grants_out <= '0;
      wr_grants_out  <= '0;
      col_stall_out  <= '0;
    end else begin
      if (grant == GNT_COL && col_grants_out != 16'hFFFF)
        col_grants_out <= col_grants_out + 16'd1;
      if (grant == GNT_WR && wr_grants_out != 16'hFFFF)
        wr_grants_out <= wr_grants_out + 16'd1;
      if (col_req_in && !col_ready_out && col_stall_out != 16'hFFFF)
        col_stall_out <= col_stall_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_map_bram_arbiter.sv
// tb_map_bram_arbiter
// Drives directed and random traffic into map_bram_arbiter backed by a
// two-cycle RAM model, predicting grants and read data from a shadow map.
// Optional build macro: MAP_ARB_STATS_EN also checks the statistics counters.
module tb_map_bram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              pixel_clk_in = 1'b0;
  logic              rst_in;
  logic              vid_active_in;
  logic [ADDR_W-1:0] vid_addr_in;
  logic [DATA_W-1:0] vid_data_out;
  logic              vid_valid_out;
  logic              col_req_in;
  logic [ADDR_W-1:0] col_addr_in;
  logic              col_ready_out;
  logic [DATA_W-1:0] col_data_out;
  logic              col_valid_out;
  logic              wr_req_in;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_ready_out;
  logic              wr_done_out;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [DATA_W-1:0] ram_din_out;
  logic              ram_we_out;
  logic [DATA_W-1:0] ram_dout_in;
`ifdef MAP_ARB_STATS_EN
  logic [15:0]       col_grants_out;
  logic [15:0]       wr_grants_out;
  logic [15:0]       col_stall_out;
`endif

  map_bram_arbiter dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .vid_active_in(vid_active_in),
    .vid_addr_in  (vid_addr_in),
    .vid_data_out (vid_data_out),
    .vid_valid_out(vid_valid_out),
    .col_req_in   (col_req_in),
    .col_addr_in  (col_addr_in),
    .col_ready_out(col_ready_out),
    .col_data_out (col_data_out),
    .col_valid_out(col_valid_out),
    .wr_req_in    (wr_req_in),
    .wr_addr_in   (wr_addr_in),
    .wr_data_in   (wr_data_in),
    .wr_ready_out (wr_ready_out),
    .wr_done_out  (wr_done_out),
    .ram_addr_out (ram_addr_out),
    .ram_din_out  (ram_din_out),
    .ram_we_out   (ram_we_out),
    .ram_dout_in  (ram_dout_in)
`ifdef MAP_ARB_STATS_EN
    ,
    .col_grants_out(col_grants_out),
    .wr_grants_out (wr_grants_out),
    .col_stall_out (col_stall_out)
`endif
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  // Two-cycle single-port RAM standing in for the map BRAM
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_p1;
  always @(posedge pixel_clk_in) begin
    if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
    rd_p1       <= mem[ram_addr_out];
    ram_dout_in <= rd_p1;
  end

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  armed = 0;

  // Cycle count and marker that registered outputs have seen a reset edge
  always @(posedge pixel_clk_in) begin
    cyc <= cyc + 1;
    if (!rst_in) armed <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference state: map contents, expected responses, round-robin memory
  typedef struct { int due; logic [DATA_W-1:0] data; } resp_t;
  resp_t             vid_q[$];
  resp_t             col_q[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  bit                last_was_wr = 1'b1;
  bit                exp_done = 1'b0;
  int                m_col_g = 0, m_wr_g = 0, m_col_stall = 0;

  // Model: predict this cycle's grant from the rules and queue the read data it will return
  always @(negedge pixel_clk_in) begin
    int g;
    resp_t r;
    g = 0;
    if (rst_in) begin
      if (vid_active_in) g = 1;
      else if (col_req_in && wr_req_in) g = last_was_wr ? 2 : 3;
      else if (col_req_in) g = 2;
      else if (wr_req_in) g = 3;
    end
    checkOutput("col_ready", 32'(col_ready_out), 32'(g == 2));
    checkOutput("wr_ready", 32'(wr_ready_out), 32'(g == 3));
    checkOutput("ram_we", 32'(ram_we_out), 32'(g == 3));
    if (g == 1) checkOutput("ram_addr_vid", 32'(ram_addr_out), 32'(vid_addr_in));
    if (g == 2) checkOutput("ram_addr_col", 32'(ram_addr_out), 32'(col_addr_in));
    if (g == 3) begin
      checkOutput("ram_addr_wr", 32'(ram_addr_out), 32'(wr_addr_in));
      checkOutput("ram_din", 32'(ram_din_out), 32'(wr_data_in));
    end
    if (armed) checkOutput("wr_done", 32'(wr_done_out), 32'(exp_done));
    exp_done = (g == 3);
    if (g == 1) begin
      r.due = cyc + 2; r.data = shadow[vid_addr_in]; vid_q.push_back(r);
    end else if (g == 2) begin
      r.due = cyc + 2; r.data = shadow[col_addr_in]; col_q.push_back(r);
      last_was_wr = 1'b0;
    end else if (g == 3) begin
      shadow[wr_addr_in] = wr_data_in;
      last_was_wr = 1'b1;
    end
    if (!rst_in) begin
      last_was_wr = 1'b1;
      while (vid_q.size() > 0 && vid_q[$].due > cyc) void'(vid_q.pop_back());
      while (col_q.size() > 0 && col_q[$].due > cyc) void'(col_q.pop_back());
      m_col_g = 0; m_wr_g = 0; m_col_stall = 0;
    end else begin
      if (g == 2 && m_col_g < 65535) m_col_g++;
      if (g == 3 && m_wr_g < 65535) m_wr_g++;
      if (col_req_in && g != 2 && m_col_stall < 65535) m_col_stall++;
    end
  end

  // Monitor: whenever a valid appears, pop the expected response and compare
  always @(negedge pixel_clk_in) begin
    if (armed) begin
      if (vid_valid_out === 1'b1) begin
        if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
          checkOutput("vid_data", 32'(vid_data_out), 32'(vid_q[0].data));
          void'(vid_q.pop_front());
        end else begin
          checkOutput("vid_valid_spurious", 32'(vid_valid_out), 32'd0);
        end
      end else if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
        checkOutput("vid_valid", 32'(vid_valid_out), 32'd1);
        void'(vid_q.pop_front());
      end
      if (col_valid_out === 1'b1) begin
        if (col_q.size() > 0 && col_q[0].due == cyc) begin
          checkOutput("col_data", 32'(col_data_out), 32'(col_q[0].data));
          void'(col_q.pop_front());
        end else begin
          checkOutput("col_valid_spurious", 32'(col_valid_out), 32'd0);
        end
      end else if (col_q.size() > 0 && col_q[0].due == cyc) begin
        checkOutput("col_valid", 32'(col_valid_out), 32'd1);
        void'(col_q.pop_front());
      end
    end
  end

  bit col_acc, wr_acc;

  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] va,
                               input logic c, input logic [ADDR_W-1:0] ca,
                               input logic w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd);
    vid_active_in = v; vid_addr_in = va;
    col_req_in = c; col_addr_in = ca;
    wr_req_in = w; wr_addr_in = wa; wr_data_in = wd;
    @(negedge pixel_clk_in);
    col_acc = col_ready_out;
    wr_acc  = wr_ready_out;
    @(posedge pixel_clk_in);
    #1;
  endtask

  initial begin
    logic [ADDR_W-1:0] idx;
    for (int i = 0; i < DEPTH; i++) begin
      idx = ADDR_W'(i);
      mem[i]    = idx[DATA_W-1:0];
      shadow[i] = idx[DATA_W-1:0];
    end
    rst_in = 1'b0;
    vid_active_in = 1'b0; vid_addr_in = '0;
    col_req_in = 1'b0; col_addr_in = '0;
    wr_req_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;

    // reset then idle
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    rst_in = 1'b1;
    repeat (4) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // video stream with a collision request waiting behind it
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, ADDR_W'(i), 1'b1, 14'd5, 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // contention: collision first, then alternating
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 14'd100, 1'b1, 14'd200, 4'h3);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // write held during active video, granted in first blank cycle
    repeat (5) applyStimulus(1'b1, 14'd40, 1'b0, '0, 1'b1, 14'd300, 4'h6);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 14'd300, 4'h6);

    // write then read of the same tile
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 14'h1234, 4'hA);
    applyStimulus(1'b0, '0, 1'b1, 14'h1234, 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // reset while a collision read is in flight
    applyStimulus(1'b0, '0, 1'b1, 14'd7, 1'b0, '0, '0);
    rst_in = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    rst_in = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 14'd9, 1'b1, 14'd11, 4'hC);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

    // random traffic with hold-until-accepted requesters
    for (int n = 0; n < 500; n++) begin
      logic v, c, w;
      logic [ADDR_W-1:0] va, ca, wa;
      logic [DATA_W-1:0] wd;
      rst_in = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 3) == 0);
      va = ADDR_W'($urandom_range(0, 31));
      if (col_req_in && !col_acc) begin
        c = col_req_in; ca = col_addr_in;
      end else begin
        c = $urandom_range(0, 1) == 1;
        ca = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
      end
      if (wr_req_in && !wr_acc) begin
        w = wr_req_in; wa = wr_addr_in; wd = wr_data_in;
      end else begin
        w = $urandom_range(0, 1) == 1;
        wa = ADDR_W'($urandom_range(0, 31));
        wd = DATA_W'($urandom);
      end
      applyStimulus(v, va, c, ca, w, wa, wd);
    end

    // drain and confirm every expected response was delivered
    rst_in = 1'b1;
    repeat (6) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    checkOutput("vid_pending", 32'(vid_q.size()), 32'd0);
    checkOutput("col_pending", 32'(col_q.size()), 32'd0);
`ifdef MAP_ARB_STATS_EN
    checkOutput("col_grants", 32'(col_grants_out), 32'(m_col_g));
    checkOutput("wr_grants", 32'(wr_grants_out), 32'(m_wr_g));
    checkOutput("col_stall", 32'(col_stall_out), 32'(m_col_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
